// File: rtl/frl_ckpt_ctrl.sv
// Branch checkpoint controller for the free register list: tags branches at dispatch,
// retires them in order, and on a mispredict flushes, restores the FRL head and squashes younger tags.
module frl_ckpt_ctrl #(
    parameter int PTR_WIDTH = 5,
    parameter int NUM_CKPT  = 4,
    parameter int TAG_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 Dis_BranchDispatch,
    input  logic                 Dis_FrlRead,
    input  logic [PTR_WIDTH-1:0] Frl_HeadPtr,
    input  logic                 Cdb_BranchValid,
    input  logic [TAG_WIDTH-1:0] Cdb_BranchTag,
    input  logic                 Cdb_BranchMispredict,
    output logic                 Ckpt_AllocAck,
    output logic [TAG_WIDTH-1:0] Ckpt_AllocTag,
    output logic                 Ckpt_Full,
    output logic                 Ckpt_Flush,
    output logic [PTR_WIDTH-1:0] Ckpt_RestorePtr,
    output logic [TAG_WIDTH:0]   Ckpt_Count
);
    localparam int CW = TAG_WIDTH + 1;

    logic [CW-1:0]                       head_q, head_d, tail_q, tail_d;
    logic [NUM_CKPT-1:0]                 valid_q, valid_d, resolved_q, resolved_d;
    logic [NUM_CKPT-1:0][PTR_WIDTH-1:0]  ptr_q, ptr_d;
    logic                                flush_q, flush_d;
    logic [PTR_WIDTH-1:0]                restore_q, restore_d;

    logic [TAG_WIDTH-1:0] head_idx, tail_idx, mp_off;
    logic [CW-1:0]        count;
    logic                 full, mp, resolve_ok, retire, ack;

    assign head_idx   = head_q[TAG_WIDTH-1:0];
    assign tail_idx   = tail_q[TAG_WIDTH-1:0];
    assign count      = tail_q - head_q;
    assign full       = (count == CW'(NUM_CKPT));
    assign mp         = Cdb_BranchValid & Cdb_BranchMispredict & valid_q[Cdb_BranchTag] & ~flush_q;
    assign resolve_ok = Cdb_BranchValid & ~Cdb_BranchMispredict & valid_q[Cdb_BranchTag] & ~flush_q;
    // Age of the mispredicted tag relative to head, modulo the slot count.
    assign mp_off     = Cdb_BranchTag - head_idx;
    // A mispredict on the head slot squashes everything, so it cannot also retire.
    assign retire     = valid_q[head_idx] & resolved_q[head_idx] & ~(mp & (mp_off == '0));
    assign ack        = Dis_BranchDispatch & ~full & ~flush_q & ~mp;

    always_comb begin
        logic [TAG_WIDTH-1:0] slot_off;
        slot_off   = '0;
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        ptr_d      = ptr_q;
        flush_d    = 1'b0;
        restore_d  = restore_q;

        if (ack) begin
            ptr_d[tail_idx]      = Frl_HeadPtr + PTR_WIDTH'(Dis_FrlRead);
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
            tail_d               = tail_q + 1'b1;
        end

        if (resolve_ok)
            resolved_d[Cdb_BranchTag] = 1'b1;

        if (retire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + 1'b1;
        end

        if (mp) begin
            tail_d    = head_q + CW'(mp_off);
            restore_d = ptr_q[Cdb_BranchTag];
            flush_d   = 1'b1;
            // Squash the mispredicted slot and everything younger than it.
            for (int i = 0; i < NUM_CKPT; i++) begin
                slot_off = TAG_WIDTH'(i) - head_idx;
                if (slot_off >= mp_off)
                    valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
            ptr_q      <= '0;
            flush_q    <= 1'b0;
            restore_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            ptr_q      <= ptr_d;
            flush_q    <= flush_d;
            restore_q  <= restore_d;
        end
    end

    assign Ckpt_AllocAck   = ack;
    assign Ckpt_AllocTag   = tail_idx;
    assign Ckpt_Full       = full;
    assign Ckpt_Flush      = flush_q;
    assign Ckpt_RestorePtr = restore_q;
    assign Ckpt_Count      = count;
endmodule

// File: tb/tb_frl_ckpt_ctrl.sv
// Directed bench for frl_ckpt_ctrl: expected grants and flush restores go into queues
// that a negedge monitor drains; occupancy and gating are checked inline.
module tb_frl_ckpt_ctrl;
    logic       clk = 1'b0;
    logic       resetb = 1'b1;
    logic       Dis_BranchDispatch = 1'b0;
    logic       Dis_FrlRead = 1'b0;
    logic [4:0] Frl_HeadPtr = '0;
    logic       Cdb_BranchValid = 1'b0;
    logic [1:0] Cdb_BranchTag = '0;
    logic       Cdb_BranchMispredict = 1'b0;
    logic       Ckpt_AllocAck;
    logic [1:0] Ckpt_AllocTag;
    logic       Ckpt_Full;
    logic       Ckpt_Flush;
    logic [4:0] Ckpt_RestorePtr;
    logic [2:0] Ckpt_Count;

    int checks = 0;
    int errors = 0;
    int alloc_q[$];
    int flush_q[$];

    frl_ckpt_ctrl #(.PTR_WIDTH(5), .NUM_CKPT(4), .TAG_WIDTH(2)) dut (
        .clk(clk), .resetb(resetb),
        .Dis_BranchDispatch(Dis_BranchDispatch), .Dis_FrlRead(Dis_FrlRead),
        .Frl_HeadPtr(Frl_HeadPtr), .Cdb_BranchValid(Cdb_BranchValid),
        .Cdb_BranchTag(Cdb_BranchTag), .Cdb_BranchMispredict(Cdb_BranchMispredict),
        .Ckpt_AllocAck(Ckpt_AllocAck), .Ckpt_AllocTag(Ckpt_AllocTag),
        .Ckpt_Full(Ckpt_Full), .Ckpt_Flush(Ckpt_Flush),
        .Ckpt_RestorePtr(Ckpt_RestorePtr), .Ckpt_Count(Ckpt_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setin(input logic d, input logic rd, input int fh,
                         input logic cv, input int ct, input logic cm);
        Dis_BranchDispatch   = d;
        Dis_FrlRead          = rd;
        Frl_HeadPtr          = 5'(fh);
        Cdb_BranchValid      = cv;
        Cdb_BranchTag        = 2'(ct);
        Cdb_BranchMispredict = cm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        setin(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        resetb = 1'b1;
        tick();
        tick();
        resetb = 1'b0;
    endtask

    // Monitor: every grant and every flush pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (Ckpt_AllocAck) begin
            checks++;
            if (alloc_q.size() == 0) begin
                errors++;
                $display("FAIL alloc_unexpected: got ack tag %0d expected no ack", Ckpt_AllocTag);
            end else begin
                int e;
                e = alloc_q.pop_front();
                if (int'(Ckpt_AllocTag) != e) begin
                    errors++;
                    $display("FAIL alloc_tag: got %0d expected %0d", Ckpt_AllocTag, e);
                end
            end
        end
        if (Ckpt_Flush) begin
            checks++;
            if (flush_q.size() == 0) begin
                errors++;
                $display("FAIL flush_unexpected: got flush ptr %0d expected no flush", Ckpt_RestorePtr);
            end else begin
                int e;
                e = flush_q.pop_front();
                if (int'(Ckpt_RestorePtr) != e) begin
                    errors++;
                    $display("FAIL restore_ptr: got %0d expected %0d", Ckpt_RestorePtr, e);
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("reset_count", Ckpt_Count, 0);
        chk("reset_full", Ckpt_Full, 0);
        chk("reset_flush", Ckpt_Flush, 0);
        chk("reset_restore", Ckpt_RestorePtr, 0);
        chk("reset_ack", Ckpt_AllocAck, 0);

        // Single dispatch captures head 5, then mispredict it to read ptr[0] back.
        alloc_q.push_back(0);
        setin(1, 0, 5, 0, 0, 0); tick();
        chk("one_count", Ckpt_Count, 1);
        flush_q.push_back(5);
        setin(0, 0, 0, 1, 0, 1); tick();
        chk("mp0_count", Ckpt_Count, 0);
        setin(1, 0, 7, 0, 0, 0); #1;
        chk("flush_no_ack", Ckpt_AllocAck, 0);
        tick();
        chk("post_flush", Ckpt_Flush, 0);

        // Fill all four slots with FrlRead set, then a fifth dispatch is refused.
        for (int i = 0; i < 4; i++) begin
            alloc_q.push_back(i);
            setin(1, 1, 2 + i, 0, 0, 0); tick();
        end
        chk("fill_count", Ckpt_Count, 4);
        chk("fill_full", Ckpt_Full, 1);
        setin(1, 1, 9, 0, 0, 0); #1;
        chk("full_no_ack", Ckpt_AllocAck, 0);
        tick();

        // Out-of-order resolution: tag 1 waits for tag 0, then both retire in turn.
        setin(0, 0, 0, 1, 1, 0); tick();
        chk("res1_count", Ckpt_Count, 4);
        tick();
        chk("res1_hold", Ckpt_Count, 4);
        setin(0, 0, 0, 1, 0, 0); tick();
        chk("res0_count", Ckpt_Count, 4);
        tick();
        chk("retire0", Ckpt_Count, 3);
        tick();
        chk("retire1", Ckpt_Count, 2);
        tick();
        chk("retire_stop", Ckpt_Count, 2);

        // Reset with occupied slots, refill, mispredict tag 1.
        do_reset();
        chk("reset2_count", Ckpt_Count, 0);
        chk("reset2_full", Ckpt_Full, 0);
        for (int i = 0; i < 4; i++) begin
            alloc_q.push_back(i);
            setin(1, 1, 2 + i, 0, 0, 0); tick();
        end
        flush_q.push_back(4);
        setin(0, 0, 0, 1, 1, 1); tick();
        chk("mp1_count", Ckpt_Count, 1);
        chk("mp1_tag", Ckpt_AllocTag, 1);
        chk("mp1_flush", Ckpt_Flush, 1);
        setin(0, 0, 0, 1, 0, 0); tick();
        chk("flush_res_ignored", Ckpt_Count, 1);
        tick();
        chk("flush_res_no_retire", Ckpt_Count, 1);
        chk("restore_hold", Ckpt_RestorePtr, 4);

        // Wrap-around: six alloc/resolve/retire rounds move head to pointer 6.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_q.push_back(i % 4);
            setin(1, 0, i, 0, 0, 0); tick();
            setin(0, 0, 0, 1, i % 4, 0); tick();
            tick();
            chk("wrap_drain", Ckpt_Count, 0);
        end
        alloc_q.push_back(2); setin(1, 0, 10, 0, 0, 0); tick();
        alloc_q.push_back(3); setin(1, 0, 11, 0, 0, 0); tick();
        alloc_q.push_back(0); setin(1, 0, 12, 0, 0, 0); tick();
        chk("wrap_tail_tag", Ckpt_AllocTag, 1);
        flush_q.push_back(12);
        setin(0, 0, 0, 1, 0, 1); tick();
        chk("wrap_mp_count", Ckpt_Count, 2);
        chk("wrap_mp_tag", Ckpt_AllocTag, 0);
        tick();

        // Dispatch and mispredict in the same cycle; then reset during the flush.
        setin(1, 0, 20, 1, 3, 1); #1;
        chk("mp_beats_alloc", Ckpt_AllocAck, 0);
        flush_q.push_back(11);
        tick();
        chk("mp3_count", Ckpt_Count, 1);
        chk("mp3_tag", Ckpt_AllocTag, 3);
        resetb = 1'b1;
        tick();
        resetb = 1'b0;
        chk("rst_flush", Ckpt_Flush, 0);
        chk("rst_count", Ckpt_Count, 0);
        chk("rst_restore", Ckpt_RestorePtr, 0);
        tick();
        tick();

        chk("alloc_q_drained", alloc_q.size(), 0);
        chk("flush_q_drained", flush_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frl_ckpt_ctrl.md
Name: frl_ckpt_ctrl

Overview:
- Branch checkpoint controller for the free register list (FRL).
- At branch dispatch it allocates a checkpoint tag and captures the FRL head pointer.
- It retires checkpoints in program order once their branches resolve correctly.
- On a mispredict it issues a one-cycle flush, restores the FRL head pointer and squashes all younger checkpoints; it sits between dispatch, CDB and FRL.

Parameters:
- PTR_WIDTH, 5, width of the FRL head pointer (includes wrap bit).
- NUM_CKPT, 4, number of checkpoint slots; must be a power of 2.
- TAG_WIDTH, 2, log2(NUM_CKPT); width of the branch tag.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetb  in  1  synchronous reset, active-high (1 = reset), sampled on rising clk.
- Dis_BranchDispatch  in  1  dispatch requests a checkpoint this cycle.
- Dis_FrlRead  in  1  dispatch pops the FRL this same cycle.
- Frl_HeadPtr  in  PTR_WIDTH  current FRL head pointer.
- Cdb_BranchValid  in  1  branch resolution broadcast valid.
- Cdb_BranchTag  in  TAG_WIDTH  tag of the resolving branch.
- Cdb_BranchMispredict  in  1  1 = mispredicted, 0 = correct.
- Ckpt_AllocAck  out  1  combinational; checkpoint granted this cycle.
- Ckpt_AllocTag  out  TAG_WIDTH  combinational; tag granted (tail index).
- Ckpt_Full  out  1  all NUM_CKPT slots occupied.
- Ckpt_Flush  out  1  registered one-cycle flush pulse (drives Cdb_Flush).
- Ckpt_RestorePtr  out  PTR_WIDTH  registered restored head (drives Cfc_FrlHeadPtr).
- Ckpt_Count  out  TAG_WIDTH+1  occupied slot count.

Behaviour:
- State:
  - Slot arrays valid[], resolved[], ptr[] (PTR_WIDTH).
  - Head and tail pointers, each TAG_WIDTH+1 bits; the extra bit is the wrap bit.
  - Slot index = low TAG_WIDTH bits of a pointer.
- Count and full:
  - Ckpt_Count = tail - head, modulo 2^(TAG_WIDTH+1).
  - Ckpt_Full = (Ckpt_Count == NUM_CKPT).
- Reset: head = tail = 0, all valid/resolved = 0, Ckpt_Flush = 0, Ckpt_RestorePtr = 0. Outputs: Ckpt_Count = 0, Ckpt_Full = 0, Ckpt_AllocAck = 0.
- Accepted mispredict (mp):
  - mp = Cdb_BranchValid & Cdb_BranchMispredict & valid[Cdb_BranchTag] & !Ckpt_Flush.
- Allocation:
  - Ckpt_AllocAck = Dis_BranchDispatch & !Ckpt_Full & !Ckpt_Flush & !mp.
  - Ckpt_AllocTag = tail[TAG_WIDTH-1:0], driven every cycle.
  - On ack: ptr[tail] <= Frl_HeadPtr + Dis_FrlRead (modulo 2^PTR_WIDTH); valid <= 1; resolved <= 0; tail++.
- Correct resolution:
  - Condition: Cdb_BranchValid & !Cdb_BranchMispredict & valid[tag] & !Ckpt_Flush.
  - Action: resolved[tag] <= 1.
  - A resolution for an invalid tag is ignored.
- Retire:
  - Each cycle, if valid[head] & resolved[head] (registered state), then valid[head] <= 0 and head++.
  - At most one retire per cycle.
  - Retire may coincide with allocation; count nets out.
- Mispredict (mp):
  - Ckpt_RestorePtr <= ptr[tag]; Ckpt_Flush <= 1 next cycle, for exactly one cycle.
  - Full pointer of tag: F = head + ((tag - head[TAG_WIDTH-1:0]) mod NUM_CKPT).
  - tail <= F; all slots from F up to the old tail are invalidated, including the mispredicted branch's own slot.
  - Slots older than the tag are untouched; a same-cycle retire of head is still applied.
  - mp takes priority over allocation (allocation is dropped, ack = 0) and over a concurrent correct resolution.
- During the Ckpt_Flush cycle:
  - No allocation.
  - All CDB resolutions are ignored.
  - Retire proceeds normally.
- Ckpt_RestorePtr holds its value until the next mp.
- Synchronous reset asserted mid-flush or with a full buffer returns all state to reset values on that edge; reset overrides all other events.

Test Plan:
- Reset, then dispatch 1 branch with Frl_HeadPtr=5, Dis_FrlRead=0 -> AllocAck=1, AllocTag=0, Count=1; ptr[0]=5.
- 4 dispatches (FrlHead 2,3,4,5, Dis_FrlRead=1) -> tags 0..3 captured 3,4,5,6; Full=1; 5th dispatch gives AllocAck=0.
- From full, resolve tag 1 correct, then tag 0 correct -> no retire until tag 0 resolves; then retire tag 0 and tag 1 on consecutive cycles; Count 4->3->2.
- With tags 0..3 valid, mispredict tag 1 -> next cycle Flush=1 for 1 cycle, RestorePtr=4 (ptr[1]), Count=1, AllocTag=1; a CDB resolve during the Flush cycle is ignored.
- Wrap-around: allocate/retire 6 branches, then mispredict on the slot at index 0 with head index 2 -> tail wraps correctly, Count = 2.
- Same-cycle dispatch + mispredict -> AllocAck=0 and tail unchanged by alloc; reset asserted during Flush -> Count=0, Flush=0 next cycle.
